// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: standard mode timing tuples and a total-length helper.
package vga_pkg;

  typedef struct packed {
    logic [11:0] active;
    logic [11:0] fp;
    logic [11:0] sync;
    logic [11:0] bp;
  } timing_t;

  // 640x480@60: 25 MHz pixel from a 100 MHz clk divided by 4
  localparam timing_t VGA640_H = '{active: 12'd640, fp: 12'd16, sync: 12'd96, bp: 12'd48};
  localparam timing_t VGA640_V = '{active: 12'd480, fp: 12'd10, sync: 12'd2, bp: 12'd33};
  localparam int VGA640_CLK_DIV = 4;

  // 800x600@72: 50 MHz clk used directly as the pixel clock
  localparam timing_t VGA800_H = '{active: 12'd800, fp: 12'd56, sync: 12'd120, bp: 12'd64};
  localparam timing_t VGA800_V = '{active: 12'd600, fp: 12'd37, sync: 12'd6, bp: 12'd23};
  localparam int VGA800_CLK_DIV = 1;

  localparam int MAX_TOTAL = 4096;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register with async and sync clear to a programmable value.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int              WIDTH   = 1,
  parameter int              DEPTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tap,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift one stage per enabled tick; clears load the inactive pattern
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= CLR_VAL;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= CLR_VAL;
    end else if (ce) begin
      stage_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign dout = stage_r[DEPTH-1];

  // tap is the value about to enter the last stage, so a parallel output
  // register can be loaded in step with dout
  generate
    if (DEPTH == 1) begin : g_tap_din
      assign tap = din;
    end else begin : g_tap_stage
      assign tap = stage_r[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: pixel tick, coordinates for an upstream renderer,
// and sync/de/rgb pins realigned to the renderer's return latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = VGA640_CLK_DIV,
  parameter int   H_ACTIVE = int'(VGA640_H.active),
  parameter int   H_FP     = int'(VGA640_H.fp),
  parameter int   H_SYNC   = int'(VGA640_H.sync),
  parameter int   H_BP     = int'(VGA640_H.bp),
  parameter int   V_ACTIVE = int'(VGA640_V.active),
  parameter int   V_FP     = int'(VGA640_V.fp),
  parameter int   V_SYNC   = int'(VGA640_V.sync),
  parameter int   V_BP     = int'(VGA640_V.bp),
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PIX_LAT  = 1,
  parameter int   RGB_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             pix_ce,
  output logic             pix_req,
  output logic [11:0]      pix_x,
  output logic [11:0]      pix_y,
  output logic             frame_start,
  output logic             line_start,
  input  logic [RGB_W-1:0] rgb_in,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [RGB_W-1:0] rgb_out
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  // 13-bit bounds so a 4096-long raster still compares correctly
  localparam logic [12:0] H_ACT_E  = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT_E  = 13'(V_ACTIVE);
  localparam logic [12:0] HS_BEG   = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VS_BEG   = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END   = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  DL_CLR   = {~HS_POL, ~VS_POL, 1'b0};

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_gen: raster totals must not exceed %0d", MAX_TOTAL);
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be 1..16");
  end
  if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_lat
    $error("vga_timing_gen: PIX_LAT must be 0..7");
  end

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             pix_ce_r;
  logic [11:0]      x_r;
  logic [11:0]      y_r;
  logic [11:0]      x_nxt_s;
  logic [11:0]      y_nxt_s;
  logic [12:0]      x_ext_s;
  logic [12:0]      y_ext_s;
  logic             hs_raw_s;
  logic             vs_raw_s;
  logic [2:0]       dl_tap_s;
  logic [2:0]       dl_out_s;
  logic [RGB_W-1:0] rgb_r;

  assign x_ext_s = {1'b0, x_r};
  assign y_ext_s = {1'b0, y_r};

  // Next divider phase and next raster position
  always_comb begin
    div_nxt_s = DIV_W'(0);
    x_nxt_s   = 12'd0;
    y_nxt_s   = y_r;
    if (div_r == DIV_LAST) begin
      div_nxt_s = DIV_W'(0);
    end else begin
      div_nxt_s = div_r + DIV_W'(1);
    end
    if (x_r == H_LAST) begin
      x_nxt_s = 12'd0;
      if (y_r == V_LAST) begin
        y_nxt_s = 12'd0;
      end else begin
        y_nxt_s = y_r + 12'd1;
      end
    end else begin
      x_nxt_s = x_r + 12'd1;
    end
  end

  // Divider, pixel tick and raster counters; dropping en parks everything at the origin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r    <= DIV_W'(0);
      pix_ce_r <= 1'b0;
      x_r      <= 12'd0;
      y_r      <= 12'd0;
    end else if (!en) begin
      div_r    <= DIV_W'(0);
      pix_ce_r <= 1'b0;
      x_r      <= 12'd0;
      y_r      <= 12'd0;
    end else begin
      div_r    <= div_nxt_s;
      pix_ce_r <= (div_nxt_s == DIV_LAST);
      if (pix_ce_r) begin
        x_r <= x_nxt_s;
        y_r <= y_nxt_s;
      end
    end
  end

  assign hs_raw_s    = (x_ext_s >= HS_BEG && x_ext_s < HS_END) ? HS_POL : ~HS_POL;
  assign vs_raw_s    = (y_ext_s >= VS_BEG && y_ext_s < VS_END) ? VS_POL : ~VS_POL;
  assign pix_req     = (x_ext_s < H_ACT_E) && (y_ext_s < V_ACT_E);
  assign pix_ce      = pix_ce_r;
  assign pix_x       = x_r;
  assign pix_y       = y_r;
  assign line_start  = pix_ce_r && (x_r == 12'd0);
  assign frame_start = pix_ce_r && (x_r == 12'd0) && (y_r == 12'd0);

  // Last stage of this line is the hs/vs/de pin register
  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIX_LAT + 1),
    .CLR_VAL (DL_CLR)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (pix_ce_r),
    .clr   (!en),
    .din   ({hs_raw_s, vs_raw_s, pix_req}),
    .tap   (dl_tap_s),
    .dout  (dl_out_s)
  );

  // Colour register loaded alongside de; the mux keeps unrequested rgb_in off the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r <= '0;
    end else if (!en) begin
      rgb_r <= '0;
    end else if (pix_ce_r) begin
      rgb_r <= dl_tap_s[0] ? rgb_in : '0;
    end
  end

  assign hs      = dl_out_s[2];
  assign vs      = dl_out_s[1];
  assign de      = dl_out_s[0];
  assign rgb_out = rgb_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations sharing one clock, with a pixel
// scoreboard on the latency-3 instance and directed checks on the others.
module tb_vga_timing_gen;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a, en_a, rst_n_b, en_b, rst_n_c, en_c;
  logic [7:0] rgb_in_a, rgb_in_b, rgb_in_c;
  logic pix_ce_a, pix_req_a, fs_a, ls_a, hs_a, vs_a, de_a;
  logic pix_ce_b, pix_req_b, fs_b, ls_b, hs_b, vs_b, de_b;
  logic pix_ce_c, pix_req_c, fs_c, ls_c, hs_c, vs_c, de_c;
  logic [11:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic [7:0] rgb_out_a, rgb_out_b, rgb_out_c;

  vga_timing_gen dut_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a), .pix_ce(pix_ce_a), .pix_req(pix_req_a),
    .pix_x(x_a), .pix_y(y_a), .frame_start(fs_a), .line_start(ls_a),
    .rgb_in(rgb_in_a), .hs(hs_a), .vs(vs_a), .de(de_a), .rgb_out(rgb_out_a));

  vga_timing_gen #(.CLK_DIV(1), .PIX_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b), .pix_ce(pix_ce_b), .pix_req(pix_req_b),
    .pix_x(x_b), .pix_y(y_b), .frame_start(fs_b), .line_start(ls_b),
    .rgb_in(rgb_in_b), .hs(hs_b), .vs(vs_b), .de(de_b), .rgb_out(rgb_out_b));

  vga_timing_gen #(.CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .en(en_c), .pix_ce(pix_ce_c), .pix_req(pix_req_c),
    .pix_x(x_c), .pix_y(y_c), .frame_start(fs_c), .line_start(ls_c),
    .rgb_in(rgb_in_c), .hs(hs_c), .vs(vs_c), .de(de_c), .rgb_out(rgb_out_c));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- instance B: renderer model and pixel scoreboard ----------------
  logic [7:0] sb_q[$];
  logic [7:0] rq_d[3];
  logic       rq_v[3];
  int         b_lines = 0;
  bit         b_mon_on = 1'b0;

  // Renderer returns pix_x[7:0] three ticks after the request, junk otherwise
  initial begin
    bit tog;
    tog = 1'b0;
    rgb_in_b = 8'h00;
    for (int i = 0; i < 3; i++) begin rq_d[i] = 8'h00; rq_v[i] = 1'b0; end
    forever begin
      @(negedge clk);
      if (pix_ce_b) begin
        tog = ~tog;
        rgb_in_b = rq_v[2] ? rq_d[2] : (tog ? 8'hFF : 8'hxx);
        rq_d[2] = rq_d[1]; rq_v[2] = rq_v[1];
        rq_d[1] = rq_d[0]; rq_v[1] = rq_v[0];
        rq_d[0] = x_b[7:0]; rq_v[0] = pix_req_b;
        if (pix_req_b) sb_q.push_back(x_b[7:0]);
      end
    end
  end

  // Monitor pops one expected colour per de cycle
  initial begin
    int de_run;
    logic [7:0] e;
    de_run = 0;
    forever begin
      @(negedge clk);
      if (b_mon_on) begin
        check("b_vs_idle", vs_b, 1);
        if (de_b) begin
          if (sb_q.size() == 0) begin
            check("b_sb_empty", 0, 1);
          end else begin
            e = sb_q.pop_front();
            check("b_rgb", rgb_out_b, e);
          end
          if (de_run == 0) check("b_first_de", rgb_out_b, 8'h00);
          if (de_run == 127) check("b_de128", rgb_out_b, 8'h7F);
          de_run++;
        end else begin
          check("b_blank_rgb", rgb_out_b, 8'h00);
          if (de_run != 0) begin
            check("b_de_len", de_run, 640);
            b_lines++;
            de_run = 0;
          end
        end
      end
    end
  end

  // ---------------- instance A helpers ----------------
  longint t_tick0;

  task automatic check_restart_a(input string tag);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); @(negedge clk);
      if (e < 3) begin
        check({tag, "_ce_early"}, pix_ce_a, 0);
      end else if (e == 3) begin
        t_tick0 = $time;
        check({tag, "_ce"}, pix_ce_a, 1);
        check({tag, "_fs"}, fs_a, 1);
        check({tag, "_ls"}, ls_a, 1);
        check({tag, "_x0"}, x_a, 0);
        check({tag, "_y0"}, y_a, 0);
      end else begin
        check({tag, "_ce_after"}, pix_ce_a, 0);
        check({tag, "_x1"}, x_a, 1);
      end
    end
  endtask

  initial begin
    int hs_low, de_clks, first_x, last_x, n_ce, hold_ce, ex, ey, fs_cnt, t_prev;
    int hx[2], hy[2], hcnt;
    bit found;

    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    rgb_in_a = 8'hA5; rgb_in_c = 8'h3C;
    repeat (3) @(negedge clk);

    // 1. reset values and release
    check("a_rst_hs", hs_a, 1);
    check("a_rst_vs", vs_a, 1);
    check("a_rst_de", de_a, 0);
    check("a_rst_rgb", rgb_out_a, 8'h00);
    check("a_rst_ce", pix_ce_a, 0);
    check("a_rst_fs", fs_a, 0);
    check("a_rst_x", x_a, 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    b_mon_on = 1'b1;
    check_restart_a("rel");

    // 2. one full line on the default raster
    hs_low = 0; de_clks = 0; first_x = -1; last_x = -1; n_ce = 1; found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (pix_ce_a && ls_a) begin
        found = 1'b1;
        break;
      end
      if (pix_ce_a) n_ce++;
      if (!hs_a) begin
        hs_low++;
        if (first_x < 0) first_x = int'(x_a);
        last_x = int'(x_a);
      end
      if (de_a) begin
        de_clks++;
        check("a_rgb_de", rgb_out_a, 8'hA5);
      end else begin
        check("a_rgb_blank", rgb_out_a, 8'h00);
      end
    end
    check("a_line_found", found, 1);
    check("a_line_period", 32'(($time - t_tick0) / 10), 3200);
    check("a_line_ticks", n_ce, 800);
    check("a_hs_low_clks", hs_low, 384);
    check("a_hs_first_x", first_x, 658);
    check("a_hs_last_x", last_x, 753);
    check("a_de_clks", de_clks, 2560);
    check("a_line1_y", y_a, 1);

    // 5. drop en mid-frame at x=300 on line 1
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (x_a == 12'd300) begin found = 1'b1; break; end
    end
    check("a_reach_300", found, 1);
    check("a_pre_drop_de", de_a, 1);
    check("a_pre_drop_rgb", rgb_out_a, 8'hA5);
    check("a_pre_drop_req", pix_req_a, 1);
    en_a = 1'b0;
    @(posedge clk); @(negedge clk);
    check("a_drop_de", de_a, 0);
    check("a_drop_rgb", rgb_out_a, 8'h00);
    check("a_drop_hs", hs_a, 1);
    check("a_drop_vs", vs_a, 1);
    check("a_drop_ce", pix_ce_a, 0);
    check("a_drop_x", x_a, 0);
    check("a_drop_y", y_a, 0);
    hold_ce = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (pix_ce_a || de_a) hold_ce++;
    end
    check("a_hold_quiet", hold_ce, 0);
    en_a = 1'b1;
    check_restart_a("reen");

    // 6. async reset pulse at x=700
    found = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (x_a == 12'd700) begin found = 1'b1; break; end
    end
    check("a_reach_700", found, 1);
    check("a_pre_arst_hs", hs_a, 0);
    #1 rst_n_a = 1'b0;
    #3;
    check("a_arst_hs", hs_a, 1);
    check("a_arst_vs", vs_a, 1);
    check("a_arst_de", de_a, 0);
    check("a_arst_rgb", rgb_out_a, 8'h00);
    check("a_arst_ce", pix_ce_a, 0);
    check("a_arst_x", x_a, 0);
    check("a_arst_ls", ls_a, 0);
    #2 rst_n_a = 1'b1;
    check_restart_a("arst");

    // 4. small raster wrap, CLK_DIV=1, HS_POL=1
    @(negedge clk);
    check("c_rst_hs", hs_c, 0);
    check("c_rst_vs", vs_c, 1);
    rst_n_c = 1'b1;
    @(posedge clk); @(negedge clk);
    ex = 0; ey = 0; hcnt = 0; fs_cnt = 0; t_prev = -1;
    hx[0] = 0; hx[1] = 0; hy[0] = 0; hy[1] = 0;
    for (int t = 0; t < 84; t++) begin
      check("c_ce", pix_ce_c, 1);
      check("c_x", x_c, ex);
      check("c_y", y_c, ey);
      check("c_req", pix_req_c, (ex < 4 && ey < 3));
      check("c_ls", ls_c, (ex == 0));
      check("c_fs", fs_c, (ex == 0 && ey == 0));
      check("c_hs", hs_c, (hcnt >= 2) ? (hx[1] == 5) : 0);
      check("c_vs", vs_c, (hcnt >= 2) ? (hy[1] != 4) : 1);
      check("c_de", de_c, (hcnt >= 2) ? (hx[1] < 4 && hy[1] < 3) : 0);
      check("c_rgb", rgb_out_c, de_c ? 8'h3C : 8'h00);
      if (fs_c) begin
        fs_cnt++;
        if (t_prev >= 0) check("c_frame_period", t - t_prev, 42);
        t_prev = t;
      end
      hx[1] = hx[0]; hy[1] = hy[0]; hx[0] = ex; hy[0] = ey; hcnt++;
      if (ex == 6) begin
        ex = 0;
        ey = (ey == 5) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
      @(negedge clk);
    end
    check("c_frame_starts", fs_cnt, 2);

    check("b_lines_seen", (b_lines >= 5), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
